// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: sequences sample -> fuzzy eval -> pump run -> cool-down.
// A one-second tick is derived from clk; the tick prescaler and the seconds
// counter restart on every state entry, so each state's timing is exact.
// Optional build macro RAIN_ABORT_EN: live rain_present during WATER aborts the
// episode (pump off, straight to COOLDOWN, episode not counted).
module irrigation_scheduler #(
  parameter int TICK_DIV        = 50000000,
  parameter int SAMPLE_PERIOD_S = 60,
  parameter int COOLDOWN_S      = 10,
  parameter int MAX_RUN_S       = 120,
  parameter int ACK_TIMEOUT_S   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        manual_start,
  output logic        sample_req,
  input  logic        sample_ack,
  input  logic [7:0]  irrigation_time,
  input  logic        rain_present,
  output logic        pump_on,
  output logic [7:0]  remaining_s,
  output logic [2:0]  state,
  output logic [15:0] cycle_count,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAMPLE   = 3'd1,
    S_EVAL     = 3'd2,
    S_WATER    = 3'd3,
    S_COOLDOWN = 3'd4
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  // Seconds counter is wide enough for any realistic period/timeout setting.
  localparam int SW = 16;
  localparam logic [7:0] RUN_MAX = 8'(MAX_RUN_S);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          req_q, req_d;
  logic          pump_q, pump_d;
  logic [7:0]    rem_q, rem_d;
  logic [15:0]   count_q, count_d;
  logic          terr_q, terr_d;
  logic [7:0]    time_q, time_d;
  logic          rain_q, rain_d;
  logic          tick;
  logic [7:0]    run;

  // Next-state, output and timer logic.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    req_d   = req_q;
    pump_d  = pump_q;
    rem_d   = rem_q;
    count_d = count_q;
    terr_d  = terr_q;
    time_d  = time_q;
    rain_d  = rain_q;
    tick    = (presc_q == PW'(TICK_DIV - 1));
    run     = (time_q > RUN_MAX) ? RUN_MAX : time_q;

    case (state_q)
      S_IDLE: begin
        if (enable && (manual_start ||
            (tick && sec_q == SW'(SAMPLE_PERIOD_S - 1)))) begin
          state_d = S_SAMPLE;
          req_d   = 1'b1;
        end
      end
      S_SAMPLE: begin
        // An ack arriving on the timeout tick still counts as a good sample.
        if (sample_ack) begin
          time_d  = irrigation_time;
          rain_d  = rain_present;
          req_d   = 1'b0;
          state_d = S_EVAL;
        end else if (tick && sec_q == SW'(ACK_TIMEOUT_S - 1)) begin
          terr_d  = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_EVAL: begin
        if (rain_q || run == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = run;
          pump_d  = 1'b1;
          state_d = S_WATER;
        end
      end
      S_WATER: begin
`ifdef RAIN_ABORT_EN
        if (rain_present) begin
          pump_d  = 1'b0;
          rem_d   = 8'd0;
          state_d = S_COOLDOWN;
        end else
`endif
        if (tick) begin
          if (rem_q <= 8'd1) begin
            rem_d   = 8'd0;
            pump_d  = 1'b0;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            state_d = S_COOLDOWN;
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end
      end
      S_COOLDOWN: begin
        if (tick && sec_q == SW'(COOLDOWN_S - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pump_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase

    // Disable overrides everything except the sticky/statistic registers.
    if (!enable) begin
      state_d = S_IDLE;
      pump_d  = 1'b0;
      req_d   = 1'b0;
      rem_d   = 8'd0;
      count_d = count_q;
      terr_d  = terr_q;
    end

    // Timebase restarts on state entry; it also stays parked while disabled.
    if (state_d != state_q || !enable) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      sec_d   = sec_q + SW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      sec_q   <= '0;
      req_q   <= 1'b0;
      pump_q  <= 1'b0;
      rem_q   <= 8'd0;
      count_q <= 16'd0;
      terr_q  <= 1'b0;
      time_q  <= 8'd0;
      rain_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      req_q   <= req_d;
      pump_q  <= pump_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      terr_q  <= terr_d;
      time_q  <= time_d;
      rain_q  <= rain_d;
    end
  end

  assign state       = state_q;
  assign sample_req  = req_q;
  assign pump_on     = pump_q;
  assign remaining_s = rem_q;
  assign cycle_count = count_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler. Stimulus pushes the expected
// sequence of state-change events (with the number of cycles spent in the
// previous state); a monitor pops and compares each time the state changes.
module tb_irrigation_scheduler;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        manual_start = 1'b0;
  logic        sample_ack = 1'b0;
  logic [7:0]  irrigation_time = 8'd0;
  logic        rain_present = 1'b0;
  logic        sample_req;
  logic        pump_on;
  logic [7:0]  remaining_s;
  logic [2:0]  state;
  logic [15:0] cycle_count;
  logic        timeout_err;

  irrigation_scheduler #(
    .TICK_DIV(TD), .SAMPLE_PERIOD_S(3), .COOLDOWN_S(2),
    .MAX_RUN_S(20), .ACK_TIMEOUT_S(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .manual_start(manual_start),
    .sample_req(sample_req), .sample_ack(sample_ack),
    .irrigation_time(irrigation_time), .rain_present(rain_present),
    .pump_on(pump_on), .remaining_s(remaining_s), .state(state),
    .cycle_count(cycle_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int dwell; int req; int pump; int rem; int cnt; int terr;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endfunction

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic abort_run(input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got state %0d required progress", why, state);
    finish_run();
  endtask

  task automatic push(input int st, input int dw, input int req, input int pump,
                      input int rem, input int cnt, input int terr);
    ev_t e;
    e.st = st; e.dwell = dw; e.req = req; e.pump = pump;
    e.rem = rem; e.cnt = cnt; e.terr = terr;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input int s);
    int b;
    b = 0;
    while (state !== s[2:0]) begin
      @(negedge clk);
      b++;
      if (b > 400) abort_run($sformatf("wait_state%0d", s));
    end
  endtask

  task automatic wait_rem(input int v);
    int b;
    b = 0;
    while (remaining_s !== v[7:0]) begin
      @(negedge clk);
      b++;
      if (b > 400) abort_run($sformatf("wait_rem%0d", v));
    end
  endtask

  task automatic pulse_start();
    manual_start = 1'b1;
    @(negedge clk);
    manual_start = 1'b0;
  endtask

  task automatic do_ack(input int t, input int r);
    int b;
    b = 0;
    while (sample_req !== 1'b1) begin
      @(negedge clk);
      b++;
      if (b > 400) abort_run("wait_req");
    end
    irrigation_time = t[7:0];
    rain_present    = r[0];
    sample_ack      = 1'b1;
    @(negedge clk);
    sample_ack   = 1'b0;
    rain_present = 1'b0;
  endtask

  // Monitor: one transaction per state change, compared against the queue head.
  initial begin
    int cnt;
    int evn;
    logic [2:0] prev;
    ev_t e;
    cnt = 0;
    evn = 0;
    prev = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        cnt = 0;
        prev = state;
      end else begin
        cnt++;
        if (state !== prev) begin
          evn++;
          $display("event %0d: state %0d->%0d dwell=%0d req=%0d pump=%0d rem=%0d cnt=%0d terr=%0d",
                   evn, prev, state, cnt, sample_req, pump_on, remaining_s,
                   cycle_count, timeout_err);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ev%0d.unexpected: got state %0d required no event", evn, state);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("ev%0d.state", evn), state, e.st);
            chk($sformatf("ev%0d.dwell", evn), cnt, e.dwell);
            chk($sformatf("ev%0d.sample_req", evn), sample_req, e.req);
            chk($sformatf("ev%0d.pump_on", evn), pump_on, e.pump);
            chk($sformatf("ev%0d.remaining_s", evn), remaining_s, e.rem);
            chk($sformatf("ev%0d.cycle_count", evn), cycle_count, e.cnt);
            chk($sformatf("ev%0d.timeout_err", evn), timeout_err, e.terr);
          end
          prev = state;
          cnt = 0;
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got no finish required finish before 200000");
    finish_run();
  end

  // Directed stimulus.
  initial begin
    int c6;
    repeat (3) @(negedge clk);
    chk("rst.state", state, 0);
    chk("rst.pump_on", pump_on, 0);
    chk("rst.sample_req", sample_req, 0);
    chk("rst.remaining_s", remaining_s, 0);
    chk("rst.cycle_count", cycle_count, 0);
    chk("rst.timeout_err", timeout_err, 0);
    reset = 1'b0;

    // 1: periodic sample, 5 s run.
    push(1, 12, 1, 0, 0, 0, 0); push(2, 1, 0, 0, 0, 0, 0);
    push(3, 1, 0, 1, 5, 0, 0);  push(4, 20, 0, 0, 0, 1, 0);
    push(0, 8, 0, 0, 0, 1, 0);
    do_ack(5, 0);
    wait_state(0);

    // 2: manual start, clamped run.
    push(1, 1, 1, 0, 0, 1, 0);  push(2, 1, 0, 0, 0, 1, 0);
    push(3, 1, 0, 1, 20, 1, 0); push(4, 80, 0, 0, 0, 2, 0);
    push(0, 8, 0, 0, 0, 2, 0);
    pulse_start();
    do_ack(200, 0);
    wait_state(0);

    // 3: rain at eval, then zero time.
    push(1, 1, 1, 0, 0, 2, 0); push(2, 1, 0, 0, 0, 2, 0); push(0, 1, 0, 0, 0, 2, 0);
    pulse_start();
    do_ack(45, 1);
    wait_state(0);
    push(1, 1, 1, 0, 0, 2, 0); push(2, 1, 0, 0, 0, 2, 0); push(0, 1, 0, 0, 0, 2, 0);
    pulse_start();
    do_ack(0, 0);
    wait_state(0);

    // 4: ack timeout, then a good episode keeps the sticky flag.
    push(1, 1, 1, 0, 0, 2, 0); push(0, 8, 0, 0, 0, 2, 1);
    pulse_start();
    wait_state(1);
    wait_state(0);
    push(1, 1, 1, 0, 0, 2, 1); push(2, 1, 0, 0, 0, 2, 1);
    push(3, 1, 0, 1, 3, 2, 1); push(4, 12, 0, 0, 0, 3, 1);
    push(0, 8, 0, 0, 0, 3, 1);
    pulse_start();
    do_ack(3, 0);
    wait_state(0);

    // 5: disable mid-water at remaining_s=7.
    push(1, 1, 1, 0, 0, 3, 1); push(2, 1, 0, 0, 0, 3, 1);
    push(3, 1, 0, 1, 10, 3, 1); push(0, 13, 0, 0, 0, 3, 1);
    pulse_start();
    do_ack(10, 0);
    wait_state(3);
    wait_rem(7);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // 6: live rain during water.
    push(1, 1, 1, 0, 0, 3, 1); push(2, 1, 0, 0, 0, 3, 1);
    push(3, 1, 0, 1, 4, 3, 1);
`ifdef RAIN_ABORT_EN
    c6 = 3;
    push(4, 9, 0, 0, 0, 3, 1);
`else
    c6 = 4;
    push(4, 16, 0, 0, 0, 4, 1);
`endif
    push(0, 8, 0, 0, 0, c6, 1);
    pulse_start();
    do_ack(4, 0);
    wait_state(3);
    wait_rem(2);
    rain_present = 1'b1;
    wait_state(0);
    rain_present = 1'b0;

    // 7: asynchronous reset mid-water drops the pump at once.
    push(1, 1, 1, 0, 0, c6, 1); push(2, 1, 0, 0, 0, c6, 1);
    push(3, 1, 0, 1, 9, c6, 1);
    pulse_start();
    do_ack(9, 0);
    wait_state(3);
    repeat (5) @(negedge clk);
    chk("pre_reset.pump_on", pump_on, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst.pump_on", pump_on, 0);
    chk("async_rst.state", state, 0);
    chk("async_rst.remaining_s", remaining_s, 0);
    chk("async_rst.cycle_count", cycle_count, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    finish_run();
  end

endmodule
